// File: rtl/operand_transmitter_pkg.sv
// Shared types for the operand transmitter: operand/instruction types, target
// descriptor, queue entry, FSM state encoding and the reserved-slot constant.
package operand_transmitter_pkg;

  typedef logic [31:0] operand_t;
  typedef logic [7:0]  instr_num_t;

  localparam logic [1:0] SLOT_RESERVED = 2'd3;

  typedef struct packed {
    logic       valid;
    instr_num_t instr;
    logic [1:0] slot;
  } tx_target_t;

  typedef struct packed {
    operand_t             value;
    tx_target_t [1:0]     targets;
  } tx_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  function automatic logic sendable(input tx_target_t t);
    return t.valid && (t.slot != SLOT_RESERVED);
  endfunction

endpackage

// File: rtl/operand_tx_fifo.sv
// Synchronous result queue with wrap-around pointers carrying an extra bit to
// tell full from empty; also exposes the entry behind the head for look-ahead.
module operand_tx_fifo
  import operand_transmitter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  tx_entry_t push_data,
  input  logic      pop,
  output tx_entry_t head,
  output tx_entry_t head_next,
  output logic      has_next,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  tx_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, count;
  logic [AW-1:0]   rd_addr_next;
  logic            do_push, do_pop;

  always_comb begin
    count        = wr_q - rd_q;
    empty        = (count == '0);
    full         = (count == PW'(DEPTH));
    has_next     = (count > PW'(1));
    do_push      = push && !full && !flush;
    do_pop       = pop && !empty && !flush;
    wr_d         = do_push ? wr_q + PW'(1) : wr_q;
    rd_d         = do_pop ? rd_q + PW'(1) : rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
    rd_addr_next = rd_q[AW-1:0] + AW'(1);
    head         = mem_q[rd_q[AW-1:0]];
    head_next    = mem_q[rd_addr_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/operand_transmitter.sv
// Queues ALU results and delivers each sendable target to the network with a
// req/ack handshake. Define OPERAND_TX_TIMEOUT_EN to abandon unacked sends.
module operand_transmitter
  import operand_transmitter_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_valid,
  output logic             result_ready,
  input  operand_t         result_value,
  input  tx_target_t [1:0] result_targets,
  input  logic             flush,
  output logic             req_out,
  output operand_t         operand_out,
  output instr_num_t       dest_instr_out,
  output logic [1:0]       dest_slot_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             timeout_err,
  output tx_state_e        state_dbg
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("operand_transmitter: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("operand_transmitter: TIMEOUT_CYCLES must be at least 1");
  end

  // Handshake: a transfer completes on the first clock edge that samples
  // ack_in=1 while req_out=1; the output fields stay frozen until then.
  tx_state_e  state_q, state_d;
  logic       idx_q, idx_d;
  logic       req_q, req_d;
  operand_t   operand_q, operand_d;
  instr_num_t dest_instr_q, dest_instr_d;
  logic [1:0] dest_slot_q, dest_slot_d;

  tx_entry_t  head, head_next, push_data, launch_entry;
  logic       has_next, full, empty, push, pop;
  logic       launch, launch_idx, send_done;

`ifdef OPERAND_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;
`endif

  assign result_ready = !full;
  assign push         = result_valid && !full && !flush;
  assign push_data    = '{value: result_value, targets: result_targets};

  operand_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .has_next  (has_next),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    req_d        = req_q;
    operand_d    = operand_q;
    dest_instr_d = dest_instr_q;
    dest_slot_d  = dest_slot_q;
    pop          = 1'b0;
    launch       = 1'b0;
    launch_idx   = 1'b0;
    launch_entry = head;
    send_done    = ack_in;
`ifdef OPERAND_TX_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (sendable(head.targets[0]) || sendable(head.targets[1])) begin
            launch     = 1'b1;
            launch_idx = !sendable(head.targets[0]);
          end else begin
            pop = 1'b1;
          end
        end
      end
      SEND: begin
`ifdef OPERAND_TX_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (!ack_in && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_d = 1'b1;
          send_done = 1'b1;
        end
`endif
        if (send_done) begin
          state_d = GAP;
          req_d   = 1'b0;
        end
      end
      GAP: begin
        if (!idx_q && sendable(head.targets[1])) begin
          launch     = 1'b1;
          launch_idx = 1'b1;
        end else begin
          // Retire the head and look straight through to the following entry.
          pop = 1'b1;
          if (has_next && (sendable(head_next.targets[0]) || sendable(head_next.targets[1]))) begin
            launch       = 1'b1;
            launch_entry = head_next;
            launch_idx   = !sendable(head_next.targets[0]);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d      = SEND;
      idx_d        = launch_idx;
      req_d        = 1'b1;
      operand_d    = launch_entry.value;
      dest_instr_d = launch_entry.targets[launch_idx].instr;
      dest_slot_d  = launch_entry.targets[launch_idx].slot;
`ifdef OPERAND_TX_TIMEOUT_EN
      tmo_cnt_d    = '0;
`endif
    end

    if (flush) begin
      state_d = IDLE;
      idx_d   = 1'b0;
      req_d   = 1'b0;
      pop     = 1'b0;
`ifdef OPERAND_TX_TIMEOUT_EN
      tmo_cnt_d = '0;
      tmo_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 1'b0;
      req_q        <= 1'b0;
      operand_q    <= '0;
      dest_instr_q <= '0;
      dest_slot_q  <= '0;
`ifdef OPERAND_TX_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      req_q        <= req_d;
      operand_q    <= operand_d;
      dest_instr_q <= dest_instr_d;
      dest_slot_q  <= dest_slot_d;
`ifdef OPERAND_TX_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

  assign req_out        = req_q;
  assign operand_out    = operand_q;
  assign dest_instr_out = dest_instr_q;
  assign dest_slot_out  = dest_slot_q;
  assign busy           = !empty || (state_q != IDLE);
  assign state_dbg      = state_q;
`ifdef OPERAND_TX_TIMEOUT_EN
  assign timeout_err    = tmo_err_q;
`else
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_operand_transmitter.sv
// Directed bench for operand_transmitter: reset, delivery order, skipping,
// full queue, back-to-back acks, flush, reset mid-send and timeout behaviour.
module tb_operand_transmitter;
  import operand_transmitter_pkg::*;

  localparam int W = 42;

  logic             clk = 1'b0;
  logic             rst;
  logic             result_valid;
  logic             result_ready;
  operand_t         result_value;
  tx_target_t [1:0] result_targets;
  logic             flush;
  logic             req_out;
  operand_t         operand_out;
  instr_num_t       dest_instr_out;
  logic [1:0]       dest_slot_out;
  logic             ack_in;
  logic             busy;
  logic             timeout_err;
  tx_state_e        state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  operand_transmitter #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_value   (result_value),
    .result_targets (result_targets),
    .flush          (flush),
    .req_out        (req_out),
    .operand_out    (operand_out),
    .dest_instr_out (dest_instr_out),
    .dest_slot_out  (dest_slot_out),
    .ack_in         (ack_in),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .state_dbg      (state_dbg)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input operand_t v,
                         input logic v0, input instr_num_t i0, input logic [1:0] s0,
                         input logic v1, input instr_num_t i1, input logic [1:0] s1);
    result_value             = v;
    result_targets[0].valid  = v0;
    result_targets[0].instr  = i0;
    result_targets[0].slot   = s0;
    result_targets[1].valid  = v1;
    result_targets[1].instr  = i1;
    result_targets[1].slot   = s1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ack_in = 1'b1; result_valid = 1'b1;
    set_res(32'hDEADBEEF, 1'b1, 8'd7, 2'd0, 1'b1, 8'd8, 2'd1);
    cycle(); cycle();
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", req_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
    vectors++; if (result_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", result_ready); end
    vectors++; if (operand_out !== 32'h0) begin miscompares++; $display("FAIL reset_operand: got %h want 0", operand_out); end
    vectors++; if (dest_instr_out !== 8'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", dest_instr_out); end
    vectors++; if (dest_slot_out !== 2'd0) begin miscompares++; $display("FAIL reset_slot: got %0d want 0", dest_slot_out); end
    vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    rst = 1'b0; ack_in = 1'b0; result_valid = 1'b0;
    cycle();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    set_res(32'h2A, 1'b1, 8'd5, 2'd0, 1'b1, 8'd9, 2'd1);
    result_valid = 1'b1;
    vectors++; if (result_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready: got %b want 1", result_ready); end
    cycle();
    result_valid = 1'b0;
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL basic_req_early: got %b want 0", req_out); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy); end
    cycle();
    vectors++; if ({req_out, operand_out, dest_instr_out, dest_slot_out} !== {1'b1, 32'h2A, 8'd5, 2'd0})
      begin miscompares++; $display("FAIL basic_t0: got %b/%h/%0d/%0d want 1/2a/5/0", req_out, operand_out, dest_instr_out, dest_slot_out); end
    cycle();
    vectors++; if ({req_out, dest_instr_out, dest_slot_out} !== {1'b1, 8'd5, 2'd0})
      begin miscompares++; $display("FAIL basic_t0_hold: got %b/%0d/%0d want 1/5/0", req_out, dest_instr_out, dest_slot_out); end
    cycle();
    ack_in = 1'b1;
    cycle();
    ack_in = 1'b0;
    vectors++; if (req_out !== 1'b0 || state_dbg !== GAP) begin miscompares++; $display("FAIL basic_gap: got req %b state %0d want 0/GAP", req_out, state_dbg); end
    cycle();
    vectors++; if ({req_out, operand_out, dest_instr_out, dest_slot_out} !== {1'b1, 32'h2A, 8'd9, 2'd1})
      begin miscompares++; $display("FAIL basic_t1: got %b/%h/%0d/%0d want 1/2a/9/1", req_out, operand_out, dest_instr_out, dest_slot_out); end
    cycle(); cycle();
    ack_in = 1'b1;
    cycle();
    ack_in = 1'b0;
    vectors++; if (req_out !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL basic_gap2: got req %b busy %b want 0/1", req_out, busy); end
    cycle();
    vectors++; if (busy !== 1'b0 || req_out !== 1'b0) begin miscompares++; $display("FAIL basic_done: got busy %b req %b want 0/0", busy, req_out); end
  endtask

  task automatic test_skip();
    set_res(32'h55, 1'b0, 8'd1, 2'd0, 1'b1, 8'd3, 2'd3);
    result_valid = 1'b1;
    cycle();
    result_valid = 1'b0;
    vectors++; if (busy !== 1'b1 || req_out !== 1'b0) begin miscompares++; $display("FAIL skip_queued: got busy %b req %b want 1/0", busy, req_out); end
    cycle();
    vectors++; if (busy !== 1'b0 || req_out !== 1'b0) begin miscompares++; $display("FAIL skip_popped: got busy %b req %b want 0/0", busy, req_out); end
    cycle();
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL skip_no_req: got %b want 0", req_out); end
  endtask

  task automatic test_full();
    int n;
    logic [W-1:0] got;
    ack_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_res(32'h100 + k, 1'b1, 8'(20 + k), 2'(k % 3), 1'b0, 8'd0, 2'd0);
      result_valid = 1'b1;
      vectors++; if (result_ready !== (k < 4)) begin miscompares++; $display("FAIL full_ready_%0d: got %b want %b", k, result_ready, (k < 4)); end
      if (k < 4) exp_q.push_back({8'(20 + k), 2'(k % 3), 32'h100 + k});
      cycle();
    end
    result_valid = 1'b0;
    vectors++; if (req_out !== 1'b1 || operand_out !== 32'h100) begin miscompares++; $display("FAIL full_head_held: got %b/%h want 1/100", req_out, operand_out); end
    vectors++; if (result_ready !== 1'b0) begin miscompares++; $display("FAIL full_still_full: got %b want 0", result_ready); end
    ack_in = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_out) begin
        got = {dest_instr_out, dest_slot_out, operand_out};
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL full_extra: got %h want none", got); end
        else begin
          if (got !== exp_q[0]) begin miscompares++; $display("FAIL full_order_%0d: got %h want %h", n, got, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        n++;
      end
      cycle();
    end
    ack_in = 1'b0;
    vectors++; if (n !== 4 || exp_q.size() != 0) begin miscompares++; $display("FAIL full_count: got %0d want 4", n); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_idle: got %b want 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int n, low_run;
    logic seen, prev_req;
    logic [W-1:0] got;
    exp_q.push_back({8'd1, 2'd0, 32'hA0});
    exp_q.push_back({8'd2, 2'd1, 32'hA0});
    exp_q.push_back({8'd3, 2'd2, 32'hB0});
    exp_q.push_back({8'd4, 2'd0, 32'hB0});
    ack_in = 1'b1;
    set_res(32'hA0, 1'b1, 8'd1, 2'd0, 1'b1, 8'd2, 2'd1);
    result_valid = 1'b1;
    cycle();
    set_res(32'hB0, 1'b1, 8'd3, 2'd2, 1'b1, 8'd4, 2'd0);
    cycle();
    result_valid = 1'b0;
    n = 0; low_run = 0; seen = 1'b0; prev_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_out) begin
        vectors++;
        if (prev_req) begin miscompares++; $display("FAIL b2b_req_held: got 2 cycles want 1"); end
        if (seen) begin
          vectors++;
          if (low_run != 1) begin miscompares++; $display("FAIL b2b_gap: got %0d want 1", low_run); end
        end
        got = {dest_instr_out, dest_slot_out, operand_out};
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_extra: got %h want none", got); end
        else begin
          if (got !== exp_q[0]) begin miscompares++; $display("FAIL b2b_order_%0d: got %h want %h", n, got, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        n++; seen = 1'b1; low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = req_out;
      cycle();
    end
    ack_in = 1'b0;
    vectors++; if (n != 4 || exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", n); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    ack_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_res(32'hC0 + k, 1'b1, 8'(40 + k), 2'd1, 1'b0, 8'd0, 2'd0);
      result_valid = 1'b1;
      cycle();
    end
    vectors++; if (req_out !== 1'b1) begin miscompares++; $display("FAIL flush_pre_send: got %b want 1", req_out); end
    flush = 1'b1; ack_in = 1'b1;
    set_res(32'hC3, 1'b1, 8'd43, 2'd0, 1'b0, 8'd0, 2'd0);
    cycle();
    flush = 1'b0; ack_in = 1'b0; result_valid = 1'b0;
    vectors++; if ({req_out, busy, result_ready} !== 3'b001) begin miscompares++; $display("FAIL flush_clear: got req/busy/ready %b%b%b want 001", req_out, busy, result_ready); end
    vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL flush_state: got %0d want IDLE", state_dbg); end
    cycle(); cycle(); cycle();
    vectors++; if (req_out !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL flush_dropped_push: got req %b busy %b want 0/0", req_out, busy); end
  endtask

  task automatic test_reset_mid_send();
    set_res(32'hD0, 1'b1, 8'd6, 2'd1, 1'b0, 8'd0, 2'd0);
    result_valid = 1'b1;
    cycle();
    result_valid = 1'b0;
    cycle();
    vectors++; if (req_out !== 1'b1) begin miscompares++; $display("FAIL rstsend_req: got %b want 1", req_out); end
    rst = 1'b1; ack_in = 1'b1;
    cycle();
    rst = 1'b0; ack_in = 1'b0;
    vectors++; if (req_out !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin miscompares++; $display("FAIL rstsend_drop: got req %b busy %b state %0d want 0/0/IDLE", req_out, busy, state_dbg); end
    cycle(); cycle();
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL rstsend_quiet: got %b want 0", req_out); end
  endtask

  task automatic test_timeout();
    int high;
    logic tmo_seen;
    ack_in = 1'b0;
    set_res(32'hE0, 1'b1, 8'd11, 2'd0, 1'b1, 8'd12, 2'd2);
    result_valid = 1'b1;
    cycle();
    result_valid = 1'b0;
    cycle();
    high = 0; tmo_seen = 1'b0;
`ifdef OPERAND_TX_TIMEOUT_EN
    for (int i = 0; i < 40 && req_out; i++) begin
      if (timeout_err) tmo_seen = 1'b1;
      high++;
      cycle();
    end
    vectors++; if (high != 16) begin miscompares++; $display("FAIL tmo_send_len: got %0d want 16", high); end
    vectors++; if (tmo_seen !== 1'b0) begin miscompares++; $display("FAIL tmo_early_pulse: got 1 want 0"); end
    vectors++; if (timeout_err !== 1'b1 || req_out !== 1'b0 || state_dbg !== GAP) begin miscompares++; $display("FAIL tmo_pulse: got tmo %b req %b state %0d want 1/0/GAP", timeout_err, req_out, state_dbg); end
    cycle();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse_width: got %b want 0", timeout_err); end
    vectors++; if ({req_out, dest_instr_out, dest_slot_out} !== {1'b1, 8'd12, 2'd2}) begin miscompares++; $display("FAIL tmo_next: got %b/%0d/%0d want 1/12/2", req_out, dest_instr_out, dest_slot_out); end
    ack_in = 1'b1;
    cycle();
    ack_in = 1'b0;
    cycle();
`else
    for (int i = 0; i < 120; i++) begin
      if (req_out) high++;
      if (timeout_err) tmo_seen = 1'b1;
      cycle();
    end
    vectors++; if (high != 120) begin miscompares++; $display("FAIL notmo_wait: got %0d want 120", high); end
    vectors++; if (tmo_seen !== 1'b0) begin miscompares++; $display("FAIL notmo_err: got 1 want 0"); end
    vectors++; if (dest_instr_out !== 8'd11) begin miscompares++; $display("FAIL notmo_hold: got %0d want 11", dest_instr_out); end
    ack_in = 1'b1;
    cycle(); cycle();
    vectors++; if ({req_out, dest_instr_out, dest_slot_out} !== {1'b1, 8'd12, 2'd2}) begin miscompares++; $display("FAIL notmo_next: got %b/%0d/%0d want 1/12/2", req_out, dest_instr_out, dest_slot_out); end
    cycle();
    ack_in = 1'b0;
    cycle();
`endif
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_idle: got %b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ack_in = 1'b0; result_valid = 1'b0;
    set_res(32'h0, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 2'd0);
    test_reset();
    test_basic();
    test_skip();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid_send();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
